tube_slave_ctrl: RTL and testbench

//  Slave-side engine for the host<->slave tube byte latches. Consumes the slave_dor/slave_dir ready flags and drives slave_wr, slave_rd_b and the slave data bus.

---
 rtl/tube_pkg.sv | 29 ++
 rtl/tube_byte_fifo.sv | 49 ++++
 rtl/tube_slave_ctrl.sv | 157 +++++++++++++++
 tb/tb_tube_slave_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared types and default constants for the slave-side tube latch engine.
package tube_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_OE,
    ST_RD_CAP,
    ST_RD_WAIT
  } tube_slave_state_t;

  localparam tube_slave_state_t STATE_RESET = ST_IDLE;

  localparam int unsigned DEFAULT_TX_DEPTH    = 4;
  localparam int unsigned DEFAULT_STROBE_CYC  = 2;
  localparam int unsigned DEFAULT_RD_CYC      = 2;
  localparam int unsigned DEFAULT_GUARD_CYC   = 3;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

  // Larger of two unsigned values, for sizing shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tube_byte_fifo.sv
// Small synchronous byte FIFO; head is read straight from the storage registers.
module tube_byte_fifo
  import tube_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_TX_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  byte_t          mem [DEPTH];
  logic  [AW:0]   wr_ptr;
  logic  [AW:0]   rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A push while full is refused; a pop while empty is ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tube_slave_ctrl.sv
// Slave-side tube latch engine: tx FIFO to slave->host latch, host->slave latch to rx stream.
// Optional watchdog enabled by defining TUBE_SLAVE_TIMEOUT_EN.
module tube_slave_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = DEFAULT_TX_DEPTH,
  parameter int unsigned STROBE_CYC  = DEFAULT_STROBE_CYC,
  parameter int unsigned RD_CYC      = DEFAULT_RD_CYC,
  parameter int unsigned GUARD_CYC   = DEFAULT_GUARD_CYC,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  slave_dor,
  input  logic  slave_dir,
  input  byte_t slave_data_i,
  output byte_t slave_data_o,
  output logic  slave_data_oe,
  output logic  slave_wr,
  output logic  slave_rd_b,
  input  byte_t tx_data,
  input  logic  tx_valid,
  output logic  tx_ready,
  output byte_t rx_data,
  output logic  rx_valid,
  input  logic  rx_ready,
  output logic  timeout_err
);

  localparam int unsigned CNT_W = $clog2(max_u(STROBE_CYC, RD_CYC) + 1);
  localparam int unsigned GW    = $clog2(GUARD_CYC + 1);

  tube_slave_state_t state;
  logic [CNT_W-1:0]  cnt;
  logic [GW-1:0]     wr_guard;
  logic [GW-1:0]     rd_guard;
  logic              last_wr;
  byte_t             fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_elig;
  logic              wr_elig;

  tube_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (state == ST_WR_HOLD),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_ready = ~fifo_full;
  assign rd_elig  = slave_dir & ~rx_valid & (rd_guard == '0);
  assign wr_elig  = slave_dor & ~fifo_empty & (wr_guard == '0);

  // Transfer sequencer, guard timers and rx holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= STATE_RESET;
      cnt           <= '0;
      wr_guard      <= '0;
      rd_guard      <= '0;
      last_wr       <= 1'b1;
      slave_wr      <= 1'b0;
      slave_rd_b    <= 1'b1;
      slave_data_oe <= 1'b0;
      slave_data_o  <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
    end else begin
      if (wr_guard != '0) wr_guard <= wr_guard - GW'(1);
      if (rd_guard != '0) rd_guard <= rd_guard - GW'(1);
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Alternate priority when both directions are ready.
          if (rd_elig && (!wr_elig || last_wr)) begin
            state      <= ST_RD_OE;
            slave_rd_b <= 1'b0;
            cnt        <= CNT_W'(RD_CYC - 1);
            last_wr    <= 1'b0;
          end else if (wr_elig) begin
            state         <= ST_WR_SETUP;
            slave_data_o  <= fifo_head;
            slave_data_oe <= 1'b1;
            last_wr       <= 1'b1;
          end
        end
        ST_WR_SETUP: begin
          state    <= ST_WR_STROBE;
          slave_wr <= 1'b1;
          cnt      <= CNT_W'(STROBE_CYC - 1);
        end
        ST_WR_STROBE: begin
          if (cnt == '0) begin
            state    <= ST_WR_HOLD;
            slave_wr <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          state         <= ST_IDLE;
          slave_data_oe <= 1'b0;
          wr_guard      <= GW'(GUARD_CYC);
        end
        ST_RD_OE: begin
          // Sample the bus on the last enabled cycle, then release the latch.
          if (cnt == '0) begin
            state      <= ST_RD_CAP;
            rx_data    <= slave_data_i;
            slave_rd_b <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RD_CAP: begin
          state    <= ST_RD_WAIT;
          rx_valid <= 1'b1;
          rd_guard <= GW'(GUARD_CYC);
        end
        ST_RD_WAIT: state <= ST_IDLE;
        default:    state <= STATE_RESET;
      endcase
    end
  end

`ifdef TUBE_SLAVE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          to_run;

  assign to_run = (~fifo_empty & ~slave_dor) | (rx_valid & ~rx_ready);

  // Watchdog: counts consecutive stalled cycles, flag is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (!to_run) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != TW'(TIMEOUT_CYC)) to_cnt <= to_cnt + TW'(1);
      if (to_cnt == TW'(TIMEOUT_CYC - 1)) timeout_err <= 1'b1;
    end
  end
`else
  // Watchdog absent; parameter retained so both builds share one interface.
  assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_tube_slave_ctrl.sv
// Scoreboard bench for tube_slave_ctrl.
module tb_tube_slave_ctrl;
  import tube_pkg::*;

  localparam int STROBE = 2;
  localparam int RDC    = 2;
  localparam int GUARD  = 3;

  logic  clk = 1'b0;
  logic  reset;
  logic  slave_dor, slave_dir;
  byte_t slave_data_i, slave_data_o;
  logic  slave_data_oe, slave_wr, slave_rd_b;
  byte_t tx_data, rx_data;
  logic  tx_valid, tx_ready, rx_valid, rx_ready, timeout_err;

  tube_slave_ctrl #(
    .TX_DEPTH(4), .STROBE_CYC(STROBE), .RD_CYC(RDC), .GUARD_CYC(GUARD), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .reset(reset), .slave_dor(slave_dor), .slave_dir(slave_dir),
    .slave_data_i(slave_data_i), .slave_data_o(slave_data_o), .slave_data_oe(slave_data_oe),
    .slave_wr(slave_wr), .slave_rd_b(slave_rd_b), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_starts = 0;
  byte_t exp_tx[$];
  byte_t exp_rx[$];
  int rise_cyc[$];
  int fall_cyc[$];
  int start_log[$];   // 1 = write started, 2 = read started

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT transfers against the expected queues.
  logic prev_wr = 1'b0, prev_rdb = 1'b1, prev_oe = 1'b0;
  int hi_len = 0, lo_len = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_wr = 1'b0; prev_rdb = 1'b1; prev_oe = 1'b0; hi_len = 0; lo_len = 0;
    end else begin
      check("bus_contention", 32'(slave_data_oe & ~slave_rd_b), 0);
      if (slave_wr) hi_len++;
      if (slave_wr && !prev_wr) begin
        rise_cyc.push_back(cyc);
        check("oe_at_strobe", 32'(slave_data_oe), 1);
        if (exp_tx.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL tx_unexpected: got 0x%0h expected no write", slave_data_o);
        end else check("tx_byte", 32'(slave_data_o), 32'(exp_tx.pop_front()));
      end
      if (!slave_wr && prev_wr) begin
        fall_cyc.push_back(cyc);
        check("strobe_len", hi_len, STROBE);
        hi_len = 0;
      end
      if (slave_data_oe && !prev_oe) start_log.push_back(1);
      if (!slave_rd_b) lo_len++;
      if (!slave_rd_b && prev_rdb) begin
        start_log.push_back(2);
        rd_starts++;
      end
      if (slave_rd_b && !prev_rdb) begin
        check("rd_low_len", lo_len, RDC);
        lo_len = 0;
      end
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no byte", rx_data);
        end else check("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      prev_wr = slave_wr; prev_rdb = slave_rd_b; prev_oe = slave_data_oe;
    end
  end

  task automatic push(input byte_t d, input logic exp_acc, input string nm);
    tx_data  = d;
    tx_valid = 1'b1;
    check(nm, 32'(tx_ready), 32'(exp_acc));
    step();
    if (exp_acc) exp_tx.push_back(d);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL %s: queues not drained tx=%0d rx=%0d", nm, exp_tx.size(), exp_rx.size());
      exp_tx.delete();
      exp_rx.delete();
    end
    repeat (12) step();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr"},      32'(slave_wr), 0);
    check({tag, "_rd_b"},    32'(slave_rd_b), 1);
    check({tag, "_oe"},      32'(slave_data_oe), 0);
    check({tag, "_data_o"},  32'(slave_data_o), 0);
    check({tag, "_rxv"},     32'(rx_valid), 0);
    check({tag, "_rxd"},     32'(rx_data), 0);
    check({tag, "_txr"},     32'(tx_ready), 1);
    check({tag, "_tmo"},     32'(timeout_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int c_push;
    reset = 1'b1; slave_dor = 1'b0; slave_dir = 1'b0; slave_data_i = '0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    step(); step();
    reset_checks("rst");
    reset = 1'b0;
    step();

    // 1: single tx byte
    slave_dor = 1'b1;
    rise_cyc.delete();
    push(8'hA5, 1'b1, "t1_accept");
    c_push = cyc;
    wait_idle(50, "t1_drain");
    check("t1_tx_ready", 32'(tx_ready), 1);
    check("t1_rises", rise_cyc.size(), 1);
    if (rise_cyc.size() >= 1) check("t1_latency", rise_cyc[0] - c_push, 2);

    // 2: single rx byte held under back-pressure
    rx_ready = 1'b0;
    slave_data_i = 8'h3C;
    exp_rx.push_back(8'h3C);
    n = rd_starts;
    slave_dir = 1'b1;
    c_push = 0;
    while (!rx_valid && c_push < 20) begin step(); c_push++; end
    check("t2_rx_latency", c_push, RDC + 2);
    repeat (10) step();
    check("t2_rxv_held", 32'(rx_valid), 1);
    check("t2_rxd_held", 32'(rx_data), 32'h3C);
    check("t2_one_read", rd_starts - n, 1);
    slave_dir = 1'b0;
    rx_ready = 1'b1;
    step(); step();
    check("t2_rxv_clear", 32'(rx_valid), 0);
    check("t2_rx_drained", exp_rx.size(), 0);

    // 3: both flags ready, alternating order
    slave_dor = 1'b0;
    push(8'h11, 1'b1, "t3_acc0");
    push(8'h22, 1'b1, "t3_acc1");
    start_log.delete();
    slave_data_i = 8'h77;
    exp_rx.push_back(8'h77);
    slave_dir = 1'b1;
    slave_dor = 1'b1;
    n = 0;
    while (slave_rd_b && n < 40) begin step(); n++; end
    slave_dir = 1'b0;
    wait_idle(100, "t3_drain");
    check("t3_starts", start_log.size(), 3);
    if (start_log.size() >= 3) begin
      check("t3_first_w", start_log[0], 1);
      check("t3_then_r",  start_log[1], 2);
      check("t3_then_w",  start_log[2], 1);
    end

    // 4: same-direction guard after a write
    slave_dor = 1'b0;
    push(8'h01, 1'b1, "t4_acc0");
    push(8'h02, 1'b1, "t4_acc1");
    rise_cyc.delete();
    fall_cyc.delete();
    slave_dor = 1'b1;
    wait_idle(100, "t4_drain");
    check("t4_rises", rise_cyc.size(), 2);
    if (rise_cyc.size() >= 2 && fall_cyc.size() >= 1)
      check("t4_guard_gap", rise_cyc[1] - fall_cyc[0], GUARD + 3);

    // 5: FIFO full
    slave_dor = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(i), 1'b1, "t5_acc");
    push(8'h04, 1'b0, "t5_full_refuse");
    check("t5_still_full", 32'(tx_ready), 0);
    tx_data = 8'h04;
    tx_valid = 1'b1;
    slave_dor = 1'b1;
    n = 0;
    while (!tx_ready && n < 30) begin step(); n++; end
    check("t5_ready_back", 32'(tx_ready), 1);
    step();
    exp_tx.push_back(8'h04);
    tx_valid = 1'b0;
    wait_idle(200, "t5_drain");

    // 6: async reset during strobe
    push(8'h5A, 1'b1, "t6_acc");
    n = 0;
    while (!slave_wr && n < 20) begin step(); n++; end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    check("midrst_queue", exp_tx.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    slave_dor = 1'b0;
    step();

    // Watchdog: slave_dor held low with data queued
    push(8'hEE, 1'b1, "tmo_acc");
    repeat (260) step();
`ifdef TUBE_SLAVE_TIMEOUT_EN
    check("tmo_set", 32'(timeout_err), 1);
`else
    check("tmo_absent", 32'(timeout_err), 0);
`endif
    slave_dor = 1'b1;
    wait_idle(50, "tmo_drain");
`ifdef TUBE_SLAVE_TIMEOUT_EN
    check("tmo_sticky", 32'(timeout_err), 1);
`else
    check("tmo_absent_end", 32'(timeout_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
